// File: rtl/data_mem_responder.sv
// Data-memory responder for the single-cycle RISC-V core: a word-organised
// synchronous RAM behind a valid/ready load/store port with sub-word read-modify-write.
module data_mem_responder #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error
);

  localparam int AW = DEPTH_LOG2 + 2;

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t state, next_state;

  logic [AW-1:0] addr_q;
  logic [1:0]    size_q;
  logic          write_q;
  logic [31:0]   wdata_q;
  logic [31:0]   old_word_q;
  logic [31:0]   rsp_rdata_q;
  logic          rsp_error_q;

  logic [31:0]   mem [0:(1 << DEPTH_LOG2) - 1];

  logic [DEPTH_LOG2-1:0] word_idx;
  logic                  funct3_illegal;
  logic                  misaligned;
  logic                  out_of_range;
  logic                  req_error;
  logic [31:0]           merged;

  assign word_idx = addr_q[AW-1:2];

  // Classification is done on the live request so the IDLE decision needs no extra cycle.
  assign funct3_illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
  assign misaligned     = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                          ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  assign out_of_range   = (req_addr[31:2] >> DEPTH_LOG2) != '0;
  assign req_error      = funct3_illegal || misaligned || out_of_range;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_error)                       next_state = RESP;
          else if (!req_write)                 next_state = READ;
          else if (req_funct3[1:0] == 2'b10)   next_state = WRITE;
          else                                 next_state = READ;
        end
      end
      READ:    next_state = write_q ? WRITE : RESP;
      WRITE:   next_state = RESP;
      RESP:    if (rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr_q      <= '0;
      size_q      <= '0;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      old_word_q  <= '0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q      <= req_addr[AW-1:0];
            size_q      <= req_funct3[1:0];
            write_q     <= req_write;
            wdata_q     <= req_wdata;
            rsp_rdata_q <= '0;
            rsp_error_q <= req_error;
          end
        end
        READ: begin
          if (write_q) old_word_q  <= mem[word_idx];
          else         rsp_rdata_q <= mem[word_idx] >> {addr_q[1:0], 3'b000};
        end
        default: ;
      endcase
    end
  end

  // Sub-word stores splice the new lane into the word fetched in READ.
  always_comb begin
    merged = old_word_q;
    case (size_q)
      2'b00:   merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      2'b01:   merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      2'b10:   merged = wdata_q;
      default: merged = old_word_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (state == WRITE) mem[word_idx] <= merged;
  end

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_error = rsp_error_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: stores, lane-shifted loads, error
// classification, response backpressure and reset in the middle of a store.
module tb_data_mem_responder;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [2:0]  req_funct3;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_error;

  int pass_count  = 0;
  int total_count = 0;

  data_mem_responder #(.DEPTH_LOG2(10)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_funct3 (req_funct3),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_error  (rsp_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total_count++;
    assert (observed === expected) pass_count++;
    else $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
  endtask

  // One complete request with rsp_ready high; latency counts edges from the accept edge.
  task automatic apply_stimulus(input logic wr, input logic [31:0] addr, input logic [2:0] f3,
                                input logic [31:0] wd, output int lat, output logic [31:0] rd,
                                output logic er);
    req_write  = wr;
    req_addr   = addr;
    req_funct3 = f3;
    req_wdata  = wd;
    req_valid  = 1'b1;
    tick();
    req_valid = 1'b0;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 12) begin
      tick();
      lat++;
    end
    rd = rsp_rdata;
    er = rsp_error;
    tick();
  endtask

  task automatic do_store(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                          input logic [31:0] wd, input int exp_lat, input logic exp_err);
    int lat;
    logic [31:0] rd;
    logic er;
    apply_stimulus(1'b1, addr, f3, wd, lat, rd, er);
    check_output({tag, "_lat"}, lat, exp_lat);
    check_output({tag, "_err"}, {31'b0, er}, {31'b0, exp_err});
    check_output({tag, "_rdata"}, rd, 32'h0);
  endtask

  task automatic do_load(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                         input logic [31:0] exp_data, input int exp_lat, input logic exp_err);
    int lat;
    logic [31:0] rd;
    logic er;
    apply_stimulus(1'b0, addr, f3, 32'h0, lat, rd, er);
    check_output({tag, "_lat"}, lat, exp_lat);
    check_output({tag, "_err"}, {31'b0, er}, {31'b0, exp_err});
    check_output({tag, "_data"}, rd, exp_data);
  endtask

  initial begin
    int lat;
    reset      = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = '0;
    req_funct3 = '0;
    req_wdata  = '0;
    rsp_ready  = 1'b1;

    #3;
    check_output("rst_req_ready", {31'b0, req_ready}, 32'h1);
    check_output("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    check_output("rst_rsp_rdata", rsp_rdata, 32'h0);
    check_output("rst_rsp_error", {31'b0, rsp_error}, 32'h0);
    tick();
    tick();
    reset = 1'b1;
    tick();

    $display("[TB] word store then load");
    do_store("st_w10", 32'h10, 3'b010, 32'hDEADBEEF, 2, 1'b0);
    do_load ("ld_w10", 32'h10, 3'b010, 32'hDEADBEEF, 2, 1'b0);

    $display("[TB] sub-word read-modify-write");
    do_store("st_w20", 32'h20, 3'b010, 32'h11223344, 2, 1'b0);
    do_store("st_b22", 32'h22, 3'b000, 32'hFFFFFFAB, 3, 1'b0);
    do_load ("ld_w20", 32'h20, 3'b010, 32'h11AB3344, 2, 1'b0);
    do_store("st_h20", 32'h20, 3'b001, 32'h0000CAFE, 3, 1'b0);
    do_load ("ld_w20b", 32'h20, 3'b010, 32'h11ABCAFE, 2, 1'b0);

    $display("[TB] lane-shifted loads");
    do_store("st_w30", 32'h30, 3'b010, 32'h8899AABB, 2, 1'b0);
    do_load ("ld_b33", 32'h33, 3'b100, 32'h00000088, 2, 1'b0);
    do_load ("ld_h32", 32'h32, 3'b101, 32'h00008899, 2, 1'b0);
    do_load ("ld_b31", 32'h31, 3'b000, 32'h008899AA, 2, 1'b0);

    $display("[TB] error classification");
    do_store("err_h31", 32'h31, 3'b001, 32'h0000FFFF, 1, 1'b1);
    do_load ("chk_w30", 32'h30, 3'b010, 32'h8899AABB, 2, 1'b0);
    do_load ("err_w42", 32'h42, 3'b010, 32'h0, 1, 1'b1);
    do_store("err_f011", 32'h10, 3'b011, 32'h0, 1, 1'b1);
    do_store("err_f110", 32'h10, 3'b110, 32'h0, 1, 1'b1);
    do_load ("chk_w10", 32'h10, 3'b010, 32'hDEADBEEF, 2, 1'b0);
    do_store("st_w00", 32'h0, 3'b010, 32'h01020304, 2, 1'b0);
    do_store("err_oor", 32'h1000, 3'b010, 32'hFFFFFFFF, 1, 1'b1);
    do_load ("chk_w00", 32'h0, 3'b010, 32'h01020304, 2, 1'b0);

    $display("[TB] response backpressure");
    rsp_ready  = 1'b0;
    req_write  = 1'b0;
    req_addr   = 32'h10;
    req_funct3 = 3'b010;
    req_valid  = 1'b1;
    tick();
    req_valid = 1'b0;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 12) begin
      tick();
      lat++;
    end
    check_output("bp_lat", lat, 2);
    req_write  = 1'b1;
    req_wdata  = 32'h0;
    req_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check_output("bp_rsp_valid", {31'b0, rsp_valid}, 32'h1);
      check_output("bp_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
      check_output("bp_req_ready", {31'b0, req_ready}, 32'h0);
      tick();
    end
    rsp_ready = 1'b1;
    check_output("bp_hs_valid", {31'b0, rsp_valid}, 32'h1);
    check_output("bp_hs_ready", {31'b0, req_ready}, 32'h0);
    tick();
    req_valid = 1'b0;
    check_output("bp_after_ready", {31'b0, req_ready}, 32'h1);
    check_output("bp_after_valid", {31'b0, rsp_valid}, 32'h0);
    do_load("bp_chk_w10", 32'h10, 3'b010, 32'hDEADBEEF, 2, 1'b0);

    $display("[TB] reset during a byte store");
    do_store("st_w50", 32'h50, 3'b010, 32'h00000000, 2, 1'b0);
    req_write  = 1'b1;
    req_addr   = 32'h50;
    req_funct3 = 3'b000;
    req_wdata  = 32'h00000077;
    req_valid  = 1'b1;
    tick();
    req_valid = 1'b0;
    #1;
    reset = 1'b0;
    #1;
    check_output("mr_req_ready", {31'b0, req_ready}, 32'h1);
    check_output("mr_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    check_output("mr_rsp_rdata", rsp_rdata, 32'h0);
    check_output("mr_rsp_error", {31'b0, rsp_error}, 32'h0);
    tick();
    reset = 1'b1;
    tick();
    do_load("mr_chk_w50", 32'h50, 3'b010, 32'h00000000, 2, 1'b0);

    $display("%0d/%0d checks passed", pass_count, total_count);
    $finish;
  end

endmodule
